// File: rtl/foc_sequencer.sv
// Host-side sequencer for the FOC core: generates the control-loop tick, issues one
// valid/ready transaction per tick, and pushes committed PID shadow images while the core is idle.
module foc_sequencer #(
    parameter int D_WIDTH  = 16,
    parameter int PID_REGS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [15:0]                 loop_period,
    input  logic [15:0]                 angle_in,
    input  logic [D_WIDTH-1:0]          currA_in,
    input  logic [D_WIDTH-1:0]          currB_in,
    input  logic [D_WIDTH-1:0]          currC_in,
    input  logic [D_WIDTH-1:0]          currT_in,
    output logic [15:0]                 angle_out,
    output logic [D_WIDTH-1:0]          currA_out,
    output logic [D_WIDTH-1:0]          currB_out,
    output logic [D_WIDTH-1:0]          currC_out,
    output logic [D_WIDTH-1:0]          currT_out,
    output logic                        valid,
    input  logic                        ready,
    input  logic                        cfg_wen,
    input  logic                        cfg_sel,
    input  logic [$clog2(PID_REGS)-1:0] cfg_addr,
    input  logic [D_WIDTH-1:0]          cfg_data,
    input  logic                        cfg_commit,
    output logic                        cfg_busy,
    output logic                        pid_d_wen,
    output logic                        pid_q_wen,
    output logic [D_WIDTH-1:0]          pid_d_addr,
    output logic [D_WIDTH-1:0]          pid_q_addr,
    output logic [D_WIDTH-1:0]          pid_d_data,
    output logic [D_WIDTH-1:0]          pid_q_data,
    output logic [15:0]                 overrun_cnt,
    output logic [15:0]                 last_latency,
    output logic [15:0]                 max_latency
);
    localparam int AW = $clog2(PID_REGS);
    localparam int NW = 2 * PID_REGS;
    localparam int IW = $clog2(NW);
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
    localparam logic [IW-1:0] Q_BASE   = IW'(PID_REGS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_BUSY, S_CFG} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t              state_q, state_d;
    logic [15:0]         tcnt_q, tcnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [15:0]         lat_q, lat_d, lat_inc;
    logic                pending_q, pending_d;
    logic [15:0]         ovr_q, ovr_d;
    logic [15:0]         last_q, last_d;
    logic [15:0]         max_q, max_d;
    logic [15:0]         angle_q;
    logic [D_WIDTH-1:0]  curr_a_q, curr_b_q, curr_c_q, curr_t_q;
    logic [D_WIDTH-1:0]  shadow_q [2][PID_REGS];
    logic                sample_en;
    logic [15:0]         period_m1;
    logic                tick;
    logic                in_cfg, q_half;
    logic [AW-1:0]       waddr;

    // A zero period behaves as a period of one; a period lowered below tcnt forces a wrap.
    assign period_m1 = (loop_period == 16'd0) ? 16'd0 : loop_period - 16'd1;
    assign tick      = enable && (tcnt_q == period_m1);
    assign tcnt_d    = !enable ? 16'd0 : (tcnt_q >= period_m1) ? 16'd0 : tcnt_q + 16'd1;
    assign lat_inc   = sat_inc(lat_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        pending_d = pending_q;
        ovr_d     = ovr_q;
        last_d    = last_q;
        max_d     = max_q;
        sample_en = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (tick) begin
                    state_d   = S_ISSUE;
                    sample_en = 1'b1;
                end else if (pending_q && ready) begin
                    state_d = S_CFG;
                    idx_d   = '0;
                end
            end
            S_ISSUE: begin
                if (ready) begin
                    state_d = S_BUSY;
                    lat_d   = 16'd0;
                end
            end
            S_BUSY: begin
                if (ready) begin
                    last_d  = lat_inc;
                    max_d   = (lat_inc > max_q) ? lat_inc : max_q;
                    state_d = S_WAIT;
                end else begin
                    lat_d = lat_inc;
                end
            end
            S_CFG: begin
                if (idx_q == LAST_IDX) begin
                    pending_d = 1'b0;
                    state_d   = S_WAIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_IDLE:  state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
        // Ticks arriving while a transaction or configuration burst is in flight are dropped.
        if (tick && (state_q == S_ISSUE || state_q == S_BUSY || state_q == S_CFG))
            ovr_d = sat_inc(ovr_q);
        if (cfg_commit && state_q != S_CFG)
            pending_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_WAIT;
            tcnt_q    <= '0;
            idx_q     <= '0;
            lat_q     <= '0;
            pending_q <= 1'b0;
            ovr_q     <= '0;
            last_q    <= '0;
            max_q     <= '0;
            angle_q   <= '0;
            curr_a_q  <= '0;
            curr_b_q  <= '0;
            curr_c_q  <= '0;
            curr_t_q  <= '0;
            for (int s = 0; s < 2; s++)
                for (int r = 0; r < PID_REGS; r++)
                    shadow_q[s][r] <= '0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
            last_q    <= last_d;
            max_q     <= max_d;
            if (sample_en) begin
                angle_q  <= angle_in;
                curr_a_q <= currA_in;
                curr_b_q <= currB_in;
                curr_c_q <= currC_in;
                curr_t_q <= currT_in;
            end
            if (cfg_wen && state_q != S_CFG)
                shadow_q[cfg_sel][cfg_addr] <= cfg_data;
        end
    end

    // Write ports are decoded straight from the burst index so reset silences them at once.
    assign in_cfg     = (state_q == S_CFG);
    assign q_half     = (idx_q >= Q_BASE);
    assign waddr      = q_half ? AW'(idx_q - Q_BASE) : AW'(idx_q);
    assign pid_d_wen  = in_cfg && !q_half;
    assign pid_q_wen  = in_cfg && q_half;
    assign pid_d_addr = pid_d_wen ? {{(D_WIDTH-AW){1'b0}}, waddr} : '0;
    assign pid_q_addr = pid_q_wen ? {{(D_WIDTH-AW){1'b0}}, waddr} : '0;
    assign pid_d_data = pid_d_wen ? shadow_q[0][waddr] : '0;
    assign pid_q_data = pid_q_wen ? shadow_q[1][waddr] : '0;

    assign valid        = (state_q == S_ISSUE);
    assign cfg_busy     = pending_q;
    assign overrun_cnt  = ovr_q;
    assign last_latency = last_q;
    assign max_latency  = max_q;
    assign angle_out    = angle_q;
    assign currA_out    = curr_a_q;
    assign currB_out    = curr_b_q;
    assign currC_out    = curr_c_q;
    assign currT_out    = curr_t_q;
endmodule

// File: tb/tb_foc_sequencer.sv
// Self-checking bench for foc_sequencer: table-driven loop scenarios plus hand-written
// configuration, collision, enable-drop and reset sequences, with sample and write scoreboards.
module tb_foc_sequencer;
    localparam int DW = 16;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [15:0]   loop_period;
    logic [15:0]   angle_in;
    logic [DW-1:0] currA_in, currB_in, currC_in, currT_in;
    logic [15:0]   angle_out;
    logic [DW-1:0] currA_out, currB_out, currC_out, currT_out;
    logic          valid;
    logic          ready;
    logic          cfg_wen, cfg_sel, cfg_commit, cfg_busy;
    logic [1:0]    cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          pid_d_wen, pid_q_wen;
    logic [DW-1:0] pid_d_addr, pid_q_addr, pid_d_data, pid_q_data;
    logic [15:0]   overrun_cnt, last_latency, max_latency;

    foc_sequencer #(.D_WIDTH(DW), .PID_REGS(NR)) dut (
        .clk(clk), .rst(rst), .enable(enable), .loop_period(loop_period),
        .angle_in(angle_in), .currA_in(currA_in), .currB_in(currB_in),
        .currC_in(currC_in), .currT_in(currT_in),
        .angle_out(angle_out), .currA_out(currA_out), .currB_out(currB_out),
        .currC_out(currC_out), .currT_out(currT_out),
        .valid(valid), .ready(ready),
        .cfg_wen(cfg_wen), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
        .pid_d_wen(pid_d_wen), .pid_q_wen(pid_q_wen),
        .pid_d_addr(pid_d_addr), .pid_q_addr(pid_q_addr),
        .pid_d_data(pid_d_data), .pid_q_data(pid_q_data),
        .overrun_cnt(overrun_cnt), .last_latency(last_latency), .max_latency(max_latency)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: ready drops after an accept and stays low for `hold` cycles.
    int hold = 6;
    int bcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b1;
            bcnt  <= 0;
        end else if (valid && ready) begin
            ready <= 1'b0;
            bcnt  <= hold - 1;
        end else if (!ready) begin
            if (bcnt == 0) ready <= 1'b1;
            else           bcnt  <= bcnt - 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    typedef struct {
        int            c;
        logic [15:0]   a;
        logic [DW-1:0] ia, ib, ic, it;
    } samp_t;
    samp_t sq[$];

    typedef struct {
        logic          sel;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t wq[$];

    // Sensor driver: fresh random inputs every cycle, each recorded for the sample scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            angle_in = 16'($urandom);
            currA_in = DW'($urandom);
            currB_in = DW'($urandom);
            currC_in = DW'($urandom);
            currT_in = DW'($urandom);
            sq.push_back('{cyc, angle_in, currA_in, currB_in, currC_in, currT_in});
        end
    end

    int   rise_cnt = 0, rise_cyc = 0, prev_rise = 0, cur_w = 0, last_w = 0;
    int   wr_count = 0, first_wr = 0, last_wr = 0;
    logic vprev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            vprev = 1'b0;
        end else begin
            while (sq.size() > 0 && sq[0].c < cyc - 1) void'(sq.pop_front());
            if (valid && !vprev) begin
                rise_cnt++;
                prev_rise = rise_cyc;
                rise_cyc  = cyc;
                cur_w     = 1;
                if (sq.size() > 0 && sq[0].c == cyc - 1) begin
                    chk("sample_angle", angle_out, sq[0].a);
                    chk("sample_currA", currA_out, sq[0].ia);
                    chk("sample_currB", currB_out, sq[0].ib);
                    chk("sample_currC", currC_out, sq[0].ic);
                    chk("sample_currT", currT_out, sq[0].it);
                end else begin
                    chk("sample_record_present", 0, 1);
                end
            end else if (valid) begin
                cur_w++;
            end
            if (!valid && vprev) last_w = cur_w;
            vprev = valid;
            if (pid_d_wen || pid_q_wen) begin
                if (pid_d_wen && pid_q_wen) chk("single_wen", 2, 1);
                if (valid) chk("valid_during_cfg", 1, 0);
                if (wq.size() == 0) begin
                    chk("unexpected_write_addr", pid_q_wen ? 32'(pid_q_addr) : 32'(pid_d_addr), -1);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_sel", pid_q_wen, e.sel);
                    chk("wr_addr", pid_q_wen ? pid_q_addr : pid_d_addr, e.addr);
                    chk("wr_data", pid_q_wen ? pid_q_data : pid_d_data, e.data);
                end
                if (wr_count == 0) first_wr = cyc;
                last_wr = cyc;
                wr_count++;
            end
        end
    end

    task automatic reset_dut();
        rst = 1'b1; enable = 1'b0; cfg_wen = 1'b0; cfg_sel = 1'b0;
        cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        wq.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic sel, input logic [1:0] addr, input logic [DW-1:0] data);
        cfg_wen = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
        @(negedge clk);
        cfg_wen = 1'b0;
    endtask

    task automatic load_shadow(input int base);
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < NR; a++)
                cfg_write(s[0], a[1:0], DW'(base + s * NR + a));
    endtask

    task automatic expect_burst(input int base, input logic zero);
        wr_count = 0;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < NR; a++)
                wq.push_back('{s[0], DW'(a), zero ? DW'(0) : DW'(base + s * NR + a)});
    endtask

    task automatic pulse_commit();
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
    endtask

    task automatic wait_rises(input int n, input int budget, input string nm);
        int t = 0;
        while (rise_cnt < n && t < budget) begin @(negedge clk); t++; end
        if (rise_cnt < n) chk({nm, "_timeout_rises"}, rise_cnt, n);
    endtask

    task automatic wait_wr(input int n, input int budget, input string nm);
        int t = 0;
        while (wr_count < n && t < budget) begin @(negedge clk); t++; end
        if (wr_count < n) chk({nm, "_timeout_writes"}, wr_count, n);
    endtask

    typedef struct {
        logic [15:0] period;
        int          hold;
        int          exp_space;
        int          exp_lat;
        int          exp_ovr;
    } vec_t;

    initial begin
        vec_t vt[4];
        int   base, r1, r2, e;

        vt[0] = '{16'd10, 6, 10, 7, 0};
        vt[1] = '{16'd5,  7, 10, 8, 2};
        vt[2] = '{16'd0,  1, 4,  2, 6};
        vt[3] = '{16'd7,  3, 7,  4, 0};

        rst = 1'b1; enable = 1'b0; loop_period = 16'd10;
        cfg_wen = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_cfg_busy", cfg_busy, 0);
        chk("rst_d_wen", pid_d_wen, 0);
        chk("rst_q_wen", pid_q_wen, 0);
        chk("rst_d_addr", pid_d_addr, 0);
        chk("rst_q_data", pid_q_data, 0);
        chk("rst_angle_out", angle_out, 0);
        chk("rst_currT_out", currT_out, 0);
        chk("rst_overrun", overrun_cnt, 0);
        chk("rst_last_lat", last_latency, 0);
        chk("rst_max_lat", max_latency, 0);

        for (int i = 0; i < 4; i++) begin
            reset_dut();
            hold = vt[i].hold;
            loop_period = vt[i].period;
            enable = 1'b1;
            base = rise_cnt;
            wait_rises(base + 3, 300, "loop");
            chk("loop_spacing", rise_cyc - prev_rise, vt[i].exp_space);
            chk("loop_valid_width", last_w, 1);
            chk("loop_last_lat", last_latency, vt[i].exp_lat);
            chk("loop_max_lat", max_latency, vt[i].exp_lat);
            chk("loop_overrun", overrun_cnt, vt[i].exp_ovr);
        end

        // Configuration commit, including writes and commits ignored while the burst runs.
        reset_dut();
        hold = 6;
        loop_period = 16'd10;
        load_shadow(1);
        expect_burst(1, 1'b0);
        pulse_commit();
        chk("commit_busy_rises", cfg_busy, 1);
        @(negedge clk);
        cfg_wen = 1'b1; cfg_sel = 1'b0; cfg_addr = 2'd0; cfg_data = 16'hBEEF; cfg_commit = 1'b1;
        @(negedge clk);
        cfg_wen = 1'b0; cfg_commit = 1'b0;
        wait_wr(8, 30, "commit");
        chk("commit_busy_last_write", cfg_busy, 1);
        chk("commit_consecutive", last_wr - first_wr, 7);
        @(negedge clk);
        chk("commit_busy_falls", cfg_busy, 0);
        repeat (15) @(negedge clk);
        chk("commit_no_rerun", wr_count, 8);
        expect_burst(1, 1'b0);
        pulse_commit();
        wait_wr(8, 30, "recommit");

        // Commit landing on the tick cycle: the transaction goes first, CFG follows.
        reset_dut();
        hold = 2;
        loop_period = 16'd10;
        load_shadow(9);
        enable = 1'b1;
        base = rise_cnt;
        wait_rises(base + 1, 40, "coll_first");
        r1 = rise_cyc;
        repeat (8) @(negedge clk);
        expect_burst(9, 1'b0);
        pulse_commit();
        wait_rises(base + 2, 30, "coll_second");
        r2 = rise_cyc;
        chk("coll_tick_wins", r2 - r1, 10);
        chk("coll_no_early_cfg", wr_count, 0);
        wait_wr(8, 30, "coll");
        chk("coll_cfg_start", first_wr - r2, 5);
        chk("coll_overrun", overrun_cnt, 1);
        chk("coll_latency", last_latency, 3);
        wait_rises(base + 3, 40, "coll_third");
        chk("coll_next_issue", rise_cyc - r2, 20);

        // Enable falls mid-transaction: it completes, then the timer stays parked at zero.
        reset_dut();
        hold = 6;
        loop_period = 16'd10;
        enable = 1'b1;
        base = rise_cnt;
        wait_rises(base + 1, 40, "en_first");
        repeat (2) @(negedge clk);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        chk("en_no_valid", rise_cnt, base + 1);
        chk("en_last_lat", last_latency, 7);
        chk("en_max_lat", max_latency, 7);
        e = cyc;
        enable = 1'b1;
        wait_rises(base + 2, 40, "en_restart");
        chk("en_timer_held", rise_cyc - e, 10);

        // Asynchronous reset on the third configuration write.
        reset_dut();
        loop_period = 16'd10;
        load_shadow(1);
        expect_burst(1, 1'b0);
        pulse_commit();
        wait_wr(3, 30, "rstcfg");
        rst = 1'b1;
        #1;
        chk("rstcfg_d_wen", pid_d_wen, 0);
        chk("rstcfg_d_addr", pid_d_addr, 0);
        chk("rstcfg_d_data", pid_d_data, 0);
        chk("rstcfg_busy", cfg_busy, 0);
        chk("rstcfg_valid", valid, 0);
        wq.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rstcfg_no_resume", wr_count, 3);
        chk("rstcfg_busy_after", cfg_busy, 0);
        expect_burst(0, 1'b1);
        pulse_commit();
        wait_wr(8, 30, "rstcfg_cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
